data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Responder (memory) end of the datapath's load/store/fetch interface: accepts one request at a time over a valid/ready handshake, waits a programmable latency, then returns data and an error flag.
- Holds a word-addressed RAM with RISC-V byte/half/word access by funct3: sign/zero-extended loads, byte-lane stores.
- Replaces the zero-latency combinational memory so the datapath can be exercised against a multi-cycle memory.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, at least 4
LATENCY, 2, cycles from request acceptance to resp_valid; at least 1
BASE_ADDR, 32'h0000_0000, byte address of word 0; word-aligned

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data; byte/half taken from low bits
req_funct3  in  3  RISC-V width/sign code
resp_valid  out  1  response present
resp_ready  in  1  requester takes the response
resp_rdata  out  32  load result; 0 for stores and errors
resp_err  out  1  misaligned, illegal funct3 or out of range

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n = 0: state IDLE, req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, latency counter = 0. RAM contents are not cleared and are kept through reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready = 1. An edge with req_valid & req_ready accepts the request and registers req_write, req_addr, req_wdata and req_funct3.
  - LATENCY = 1: go to RESP.
  - Otherwise: load counter with LATENCY-1 and go to WAIT.
- WAIT: req_ready = 0. Counter decrements each edge; on the edge where it is 1, go to RESP.
- Timing: resp_valid rises exactly LATENCY edges after the accept edge.
- Memory access happens on the edge that enters RESP:
  - Store writes commit on that edge.
  - resp_rdata and resp_err are registered on that edge.
- RESP: resp_valid = 1. resp_rdata and resp_err stay stable until resp_ready = 1. The handshake edge goes to IDLE and drops resp_valid.
- No overlap: req_valid is ignored in WAIT and RESP. Minimum spacing between accepts is LATENCY+1 cycles.
- Decode: offset = addr - BASE_ADDR; word index = offset[31:2]; lane = addr[1:0]. Index >= DEPTH gives err.
- funct3 rules:
  - Loads: 000 lb (sign-extend byte at lane), 001 lh, 010 lw, 100 lbu (zero-extend), 101 lhu. Codes 011, 110 and 111 give err.
  - Stores: 000 sb writes wdata[7:0] to lane. 001 sh writes wdata[15:0] to lanes addr[1]*2 and addr[1]*2+1. 010 sw writes the full word. Any other code gives err.
- Alignment: half needs addr[0] = 0; word needs addr[1:0] = 00; otherwise err.
- On any err: no RAM write, resp_rdata = 0, resp_err = 1. The transaction still completes normally through RESP.
- Stores: resp_rdata = 0. Bytes outside the written lanes are unchanged.
- Reset mid-operation: rst_n low in WAIT aborts the transaction. An uncommitted store is dropped; resp_valid is 0 immediately. A store already committed on entry to RESP remains.
- Simultaneous events: a resp handshake edge does not also accept a new request; acceptance waits for IDLE.

Test Plan:
- LATENCY=2, sw 0xDEADBEEF @0x10, then lw 0x10 -> each resp_valid rises 2 edges after accept; lw rdata = 0xDEADBEEF, err = 0; sw rdata = 0.
- sb wdata=0x00000080 @0x13, then lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lw 0x10 -> 0x80ADBEEF; lhu 0x12 -> 0x000080AD.
- Misaligned/illegal: lh @0x11, sw @0x12, load funct3=011 -> err = 1, rdata = 0; following lw 0x10 unchanged (0x80ADBEEF).
- Backpressure: hold resp_ready = 0 for 5 cycles with req_valid = 1 -> resp_valid, rdata and err stable; req_ready = 0; no second accept until one cycle after the handshake.
- Reset in WAIT: sw 0x12345678 @0x20 over an old value of 0x0000AAAA, drop rst_n one cycle after accept -> resp_valid = 0 and req_ready = 0 at once; after release, lw 0x20 -> 0x0000AAAA.
- Range/latency: lw @BASE_ADDR+4*DEPTH -> err = 1. Rebuild with LATENCY=1: lw -> resp_valid in the cycle right after the accept edge.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle memory responder: one request at a time over valid/ready, a programmable
// response latency, and a word RAM with RISC-V byte/half/word loads and stores.
module data_mem_responder #(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned LATENCY   = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [2:0]  req_funct3_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wr_q;
   logic [31:0]   addr_q, wdata_q;
   logic [2:0]    f3_q;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [3:0][7:0] mem_q [DEPTH];

   logic          accept, enter_resp, we;
   logic          cur_wr;
   logic [31:0]   cur_addr, cur_wdata, offset;
   logic [2:0]    cur_f3;
   logic [29:0]   idx;
   logic [1:0]    lane;
   logic [3:0][7:0] word;
   logic [7:0]    byte_v;
   logic [15:0]   half_v;
   logic [31:0]   ld, wbits;
   logic [3:0]    bmask;

   // State register and request/response capture
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            wr_q    <= req_write_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            f3_q    <= req_funct3_i;
         end
         if (enter_resp) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (req_valid_i) begin
            if (LATENCY == 1) state_d = RESP;
            else begin
               state_d = WAIT;
               cnt_d   = CW'(LATENCY - 1);
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = RESP;
         end
         RESP: if (resp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      req_ready_o  = rst_ni && (state_q == IDLE);
      resp_valid_o = (state_q == RESP);
      resp_rdata_o = rdata_q;
      resp_err_o   = err_q;
   end

   assign accept     = (state_q == IDLE) && req_valid_i;
   assign enter_resp = (state_d == RESP) && (state_q != RESP);

   // With LATENCY=1 the access happens on the accept edge, so decode from the live inputs
   always_comb begin
      cur_wr    = (state_q == IDLE) ? req_write_i  : wr_q;
      cur_addr  = (state_q == IDLE) ? req_addr_i   : addr_q;
      cur_wdata = (state_q == IDLE) ? req_wdata_i  : wdata_q;
      cur_f3    = (state_q == IDLE) ? req_funct3_i : f3_q;
      offset    = cur_addr - BASE_ADDR;
      idx       = offset[31:2];
      lane      = offset[1:0];
      word      = mem_q[idx[AW-1:0]];
      byte_v    = word[lane];
      half_v    = lane[1] ? {word[3], word[2]} : {word[1], word[0]};
      ld        = '0;
      wbits     = '0;
      bmask     = '0;
      err_d     = ({2'b00, idx} >= 32'(DEPTH));
      case (cur_f3)
         3'b000: begin
            ld    = {{24{byte_v[7]}}, byte_v};
            bmask = 4'b0001 << lane;
            wbits = {4{cur_wdata[7:0]}};
         end
         3'b001: begin
            if (lane[0]) err_d = 1'b1;
            ld    = {{16{half_v[15]}}, half_v};
            bmask = lane[1] ? 4'b1100 : 4'b0011;
            wbits = {2{cur_wdata[15:0]}};
         end
         3'b010: begin
            if (lane != 2'b00) err_d = 1'b1;
            ld    = word;
            bmask = 4'b1111;
            wbits = cur_wdata;
         end
         3'b100: begin
            if (cur_wr) err_d = 1'b1;
            ld = {24'b0, byte_v};
         end
         3'b101: begin
            if (cur_wr || lane[0]) err_d = 1'b1;
            ld = {16'b0, half_v};
         end
         default: err_d = 1'b1;
      endcase
      rdata_d = (err_d || cur_wr) ? 32'b0 : ld;
      we      = enter_resp && cur_wr && !err_d;
   end

   // RAM is deliberately not reset; contents survive rst_ni
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 4; b++)
         if (we && bmask[b]) mem_q[idx[AW-1:0]][b] <= wbits[b*8 +: 8];
   end

endmodule
